// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared FSM encoding, defaults and tick increment helper for clk_rst_gen
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES = 16;

  // Phase increment for a tick of f_tick Hz on an f_clk Hz clock with an acc_w-bit accumulator.
  function automatic longint unsigned tick_inc_for(input longint unsigned f_clk,
                                                   input longint unsigned f_tick,
                                                   input int unsigned acc_w);
    return (f_tick << acc_w) / f_clk;
  endfunction

  localparam longint unsigned UART_16X_115200_AT_48M = tick_inc_for(64'd48_000_000, 64'd1_843_200, 24);

endpackage

// File: rtl/clk_rst_gen_tick_gen.sv
// rtl/clk_rst_gen_tick_gen.sv - one fractional clock-enable channel built on a phase accumulator
module tick_gen #(
  parameter int ACC_W = 24
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // The accumulator is cleared whenever disabled so every run starts from phase 0.
  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/clk_rst_gen.sv
// rtl/clk_rst_gen.sv - PLL lock qualification, stretched system reset and fractional tick strobes
module clk_rst_gen
  import clk_rst_pkg::*;
#(
  parameter int                        LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int                        HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int                        NUM_TICKS   = 2,
  parameter int                        ACC_W       = 24,
  parameter logic [NUM_TICKS*ACC_W-1:0] TICK_INC   = {24'h400000, 24'h800000}
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pll_locked,
  output logic                 sys_resetn,
  output logic                 ready,
  output logic [NUM_TICKS-1:0] tick,
  output logic [7:0]           lock_loss_count
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             sync_q;
  logic             lk;
  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             count_loss;
  logic             run_q;
  logic             tick_enable;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= 1'b0;
      lk     <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lk     <= sync_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      run_q           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      run_q <= (state == ST_RUN);
      if (count_loss && lock_loss_count != 8'hFF)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  // A low lk always wins, so a drop on the final FILTER/HOLD cycle still goes to IDLE.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    count_loss = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lk) begin
          next_state = ST_FILTER;
          cnt_next   = '0;
        end
      end
      ST_FILTER: begin
        if (!lk) begin
          next_state = ST_IDLE;
        end else if (cnt == LOCK_LAST) begin
          next_state = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lk) begin
          next_state = ST_IDLE;
        end else if (cnt == HOLD_LAST) begin
          next_state = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lk) begin
          next_state = ST_IDLE;
          count_loss = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign sys_resetn = run_q;
  assign ready      = run_q;

  // Gating on both terms delays the first tick past reset release and kills ticks as soon as RUN is left.
  assign tick_enable = run_q && (state == ST_RUN);

  for (genvar i = 0; i < NUM_TICKS; i++) begin : g_tick
    tick_gen #(
      .ACC_W (ACC_W)
    ) u_tick_gen (
      .clock  (clock),
      .resetn (resetn),
      .enable (tick_enable),
      .inc    (TICK_INC[i*ACC_W +: ACC_W]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb/tb_clk_rst_gen.sv - directed self-checking bench for clk_rst_gen
module tb_clk_rst_gen;

  logic       clock;
  logic       resetn;
  logic       pll_locked;
  logic       sys_resetn;
  logic       ready;
  logic [2:0] tick;
  logic [7:0] lock_loss_count;

  int n_cmp = 0;
  int n_err = 0;

  clk_rst_gen #(
    .LOCK_CYCLES (8),
    .HOLD_CYCLES (4),
    .NUM_TICKS   (3),
    .ACC_W       (24),
    .TICK_INC    ({24'h555555, 24'h400000, 24'h800000})
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .pll_locked      (pll_locked),
    .sys_resetn      (sys_resetn),
    .ready           (ready),
    .tick            (tick),
    .lock_loss_count (lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pll_locked is high at every sampled edge c except c==drop; release expected at cycle rel.
  task automatic qualify(input string tag, input int drop, input int rel);
    int bad = 0;
    for (int c = 0; c <= rel + 1; c++) begin
      pll_locked = (c != drop);
      @(negedge clock);
      if (sys_resetn !== 1'(c >= rel)) bad++;
      if (ready !== 1'(c >= rel)) bad++;
      if (tick !== 3'b000) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic lose_and_relock(input string tag);
    int bad = 0;
    pll_locked = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clock);
      if (sys_resetn !== 1'(c < 3)) bad++;
      if (c == 3 && (tick !== 3'b000 || ready !== 1'b0)) bad++;
    end
    pll_locked = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clock);
      if (sys_resetn !== 1'(c >= 15)) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int c0 = 0, c1 = 0, c2 = 0, dbl = 0, badgap = 0, last2 = -1;
    logic [2:0] prev;

    resetn     = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_sys_resetn", sys_resetn, 0);
    check("rst_ready", ready, 0);
    check("rst_tick", tick, 0);
    check("rst_loss_count", lock_loss_count, 0);

    resetn = 1'b1;
    qualify("clean_lock_release", -1, 15);

    prev = tick;
    for (int n = 17; n <= 1016; n++) begin
      @(negedge clock);
      if (n == 17) check("first_tick", tick, 3'b001);
      if (n <= 416) begin
        c0 += int'(tick[0]);
        c1 += int'(tick[1]);
      end
      if ((tick & prev) != 3'b000) dbl++;
      if (tick[2]) begin
        if (last2 >= 0 && (n - last2 < 3 || n - last2 > 4)) badgap++;
        last2 = n;
        c2++;
      end
      prev = tick;
    end
    check("ch0_ticks_400", c0, 200);
    check("ch1_ticks_400", c1, 100);
    check("tick_width", dbl, 0);
    check("ch2_gap_3_or_4", badgap, 0);
    check("ch2_ticks_1000_range", 32'(c2 >= 332 && c2 <= 334), 1);

    lose_and_relock("loss1");
    check("loss_count_1", lock_loss_count, 1);
    lose_and_relock("loss2");
    lose_and_relock("loss3");
    check("loss_count_3", lock_loss_count, 3);

    resetn = 1'b0;
    @(negedge clock);
    check("midrun_rst_sys_resetn", sys_resetn, 0);
    check("midrun_rst_ready", ready, 0);
    check("midrun_rst_tick", tick, 0);
    check("midrun_rst_count", lock_loss_count, 0);
    resetn = 1'b1;
    qualify("requalify_after_reset", -1, 15);
    check("reset_not_a_loss", lock_loss_count, 0);

    resetn = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    qualify("glitch_in_filter", 6, 22);

    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    qualify("drop_last_filter", 8, 24);

    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    qualify("drop_last_hold", 12, 28);

    for (int k = 0; k < 256; k++) lose_and_relock("loss_sat_loop");
    check("loss_count_sat", lock_loss_count, 255);
    lose_and_relock("loss_sat_extra");
    check("loss_count_hold_255", lock_loss_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
